axi_st_rx: RTL and testbench

AXI-Stream receiver: the slave-side endpoint of the team's AXI-Stream interface (slave modport signal set). Accepts beats into a show-ahead FIFO and presents them to local logic through a simple valid/pop read port. Also counts packets, reports occupancy and flags per-packet header violations. Sits at every block ingress that consumes an AXI-Stream.

---
 rtl/axi_st_rx_if.sv | 31 +++
 rtl/axi_st_rx.sv | 163 ++++++++++++++++
 tb/tb_axi_st_rx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_st_rx_if.sv
// AXI-Stream signal bundle shared by stream producers and the axi_st_rx ingress endpoint.
// The master modport drives a beat and the slave modport returns tready.
interface axi_st_rx_if #(
  parameter int SYMBOL_W   = 8,
  parameter int SYMBOL_NUM = 8,
  parameter int TID_W      = 8,
  parameter int TDEST_W    = 8,
  parameter int TUSER_W    = 8
);
  localparam int DATA_W = SYMBOL_W * SYMBOL_NUM;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [SYMBOL_NUM-1:0] tstrb;
  logic [SYMBOL_NUM-1:0] tkeep;
  logic                  tlast;
  logic [TID_W-1:0]      tid;
  logic [TDEST_W-1:0]    tdest;
  logic [TUSER_W-1:0]    tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi_st_rx.sv
// AXI-Stream ingress: show-ahead beat FIFO with a valid/pop read port, packet counter,
// occupancy report and a sticky per-packet tid/tdest consistency check.
//
// state | meaning
// IDLE  | no packet open; next accepted beat starts a packet
// PKT   | packet open; header latched, beats checked against it
module axi_st_rx #(
  parameter int SYMBOL_W   = 8,
  parameter int SYMBOL_NUM = 8,
  parameter int TID_W      = 8,
  parameter int TDEST_W    = 8,
  parameter int TUSER_W    = 8,
  parameter int DEPTH      = 8,
  parameter int PKT_CNT_W  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  axi_st_rx_if.slave                         s,
  output logic                               rd_valid,
  input  logic                               rd_en,
  output logic [SYMBOL_W*SYMBOL_NUM-1:0]     rd_data,
  output logic [SYMBOL_NUM-1:0]              rd_keep,
  output logic                               rd_last,
  output logic [TID_W-1:0]                   rd_id,
  output logic [TDEST_W-1:0]                 rd_dest,
  output logic [TUSER_W-1:0]                 rd_user,
  output logic [$clog2(SYMBOL_NUM+1)-1:0]    rd_nbytes,
  output logic [$clog2(DEPTH+1)-1:0]         fill,
  output logic [PKT_CNT_W-1:0]               pkt_cnt,
  output logic                               in_pkt,
  output logic                               err_hdr,
  input  logic                               err_clr
);
  localparam int DATA_W = SYMBOL_W * SYMBOL_NUM;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int NB_W   = $clog2(SYMBOL_NUM + 1);

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [SYMBOL_NUM-1:0] keep;
    logic                  last;
    logic [TID_W-1:0]      id;
    logic [TDEST_W-1:0]    dest;
    logic [TUSER_W-1:0]    user;
  } entry_t;

  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  entry_t               mem_q [DEPTH];
  entry_t               entry_in;
  entry_t               head;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 tready_q, tready_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                 err_q, err_d;
  state_t               state_q, state_d;
  logic [TID_W-1:0]     tid_q, tid_d;
  logic [TDEST_W-1:0]   dest_q, dest_d;
  logic                 accept, store, pop, viol;
  logic [NB_W-1:0]      nbytes;
  logic                 unused_tstrb;

  // tstrb is part of the bus contract but carries no meaning for this endpoint
  assign unused_tstrb = ^s.tstrb;

  assign accept   = s.tvalid & tready_q;
  assign store    = accept & ((|s.tkeep) | s.tlast);
  assign rd_valid = (fill_q != '0);
  assign pop      = rd_en & rd_valid;

  assign entry_in = '{data: s.tdata, keep: s.tkeep, last: s.tlast,
                      id: s.tid, dest: s.tdest, user: s.tuser};

  assign wptr_d    = wptr_q + PTR_W'(store);
  assign rptr_d    = rptr_q + PTR_W'(pop);
  assign fill_d    = fill_q + FILL_W'(store) - FILL_W'(pop);
  // Registered so a pop at full only reopens the input on the following cycle
  assign tready_d  = (fill_d < FILL_W'(DEPTH));
  assign pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(accept & s.tlast);

  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wptr_q] <= entry_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      fill_q    <= '0;
      tready_q  <= 1'b0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
      state_q   <= ST_IDLE;
      tid_q     <= '0;
      dest_q    <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fill_q    <= fill_d;
      tready_q  <= tready_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
      state_q   <= state_d;
      tid_q     <= tid_d;
      dest_q    <= dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tid_d   = tid_q;
    dest_d  = dest_q;
    viol    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && !s.tlast) begin
          state_d = ST_PKT;
          tid_d   = s.tid;
          dest_d  = s.tdest;
        end
      end
      ST_PKT: begin
        if (accept) begin
          viol = (s.tid != tid_q) || (s.tdest != dest_q);
          if (s.tlast) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new violation outranks a coincident clear
  assign err_d = viol | (err_q & ~err_clr);

  assign head = rd_valid ? mem_q[rptr_q] : '0;

  always_comb begin
    nbytes = '0;
    for (int i = 0; i < SYMBOL_NUM; i++) begin
      nbytes = nbytes + NB_W'(head.keep[i]);
    end
  end

  assign s.tready  = tready_q;
  assign rd_data   = head.data;
  assign rd_keep   = head.keep;
  assign rd_last   = head.last;
  assign rd_id     = head.id;
  assign rd_dest   = head.dest;
  assign rd_user   = head.user;
  assign rd_nbytes = nbytes;
  assign fill      = fill_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign in_pkt    = (state_q == ST_PKT);
  assign err_hdr   = err_q;
endmodule

// File: tb/tb_axi_st_rx.sv
// Directed bench for axi_st_rx: a negedge monitor keeps a scoreboard of stored beats
// and checks each popped head; the initial block walks through the scenarios.
module tb_axi_st_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        rd_valid, rd_last, in_pkt, err_hdr;
  logic [63:0] rd_data;
  logic [7:0]  rd_keep, rd_id, rd_dest, rd_user;
  logic [3:0]  rd_nbytes;
  logic [3:0]  fill;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  axi_st_rx_if #(.SYMBOL_W(8), .SYMBOL_NUM(8), .TID_W(8), .TDEST_W(8), .TUSER_W(8)) s_if ();

  axi_st_rx #(
    .SYMBOL_W(8), .SYMBOL_NUM(8), .TID_W(8), .TDEST_W(8), .TUSER_W(8),
    .DEPTH(8), .PKT_CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s(s_if),
    .rd_valid(rd_valid), .rd_en(rd_en), .rd_data(rd_data), .rd_keep(rd_keep),
    .rd_last(rd_last), .rd_id(rd_id), .rd_dest(rd_dest), .rd_user(rd_user),
    .rd_nbytes(rd_nbytes), .fill(fill), .pkt_cnt(pkt_cnt), .in_pkt(in_pkt),
    .err_hdr(err_hdr), .err_clr(err_clr)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic [7:0]  user;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_pkts = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (s_if.tvalid && s_if.tready) begin
        if (s_if.tlast) exp_pkts++;
        if (s_if.tkeep != 8'h00 || s_if.tlast)
          sb.push_back('{s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser});
      end
      if (rd_en && rd_valid) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_keep", 64'(rd_keep), 64'(e.keep));
          chk("rd_last", 64'(rd_last), 64'(e.last));
          chk("rd_id", 64'(rd_id), 64'(e.id));
          chk("rd_dest", 64'(rd_dest), 64'(e.dest));
          chk("rd_user", 64'(rd_user), 64'(e.user));
          chk("rd_nbytes", 64'(rd_nbytes), 64'($countones(e.keep)));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                          input logic [7:0] id, input logic [7:0] dest);
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tstrb  = k;
    s_if.tlast  = l;
    s_if.tid    = id;
    s_if.tdest  = dest;
    s_if.tuser  = d[7:0] ^ 8'h5a;
    s_if.tvalid = 1'b1;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l,
                      input logic [7:0] id, input logic [7:0] dest);
    bit done = 1'b0;
    set_beat(d, k, l, id, dest);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = s_if.tready;
      cyc();
    end
    s_if.tvalid = 1'b0;
    chk("accept_in_time", 64'(done), 64'd1);
  endtask

  task automatic pop(input int n);
    rd_en = 1'b1;
    repeat (n) cyc();
    rd_en = 1'b0;
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tstrb  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = '0;
    s_if.tdest  = '0;
    s_if.tuser  = '0;
    repeat (2) cyc();
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_in_pkt", 64'(in_pkt), 64'd0);
    chk("rst_err", 64'(err_hdr), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_tready", 64'(s_if.tready), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("post_rst_tready", 64'(s_if.tready), 64'd1);

    // 3-beat packet, no pops
    send(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 8'd5, 8'd1);
    send(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 8'd5, 8'd1);
    send(64'h9999_AAAA_BBBB_CCCC, 8'h0F, 1'b1, 8'd5, 8'd1);
    chk("t1_fill", 64'(fill), 64'd3);
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("t1_in_pkt", 64'(in_pkt), 64'd0);
    chk("t1_head_nbytes", 64'(rd_nbytes), 64'd8);
    pop(3);
    chk("t1_rd_valid_empty", 64'(rd_valid), 64'd0);
    chk("t1_rd_data_empty", rd_data, 64'd0);

    // fill to DEPTH, then pop one while the 9th beat waits
    for (int i = 0; i < 8; i++) send(64'(i) + 64'hA000, 8'hFF, 1'b0, 8'd1, 8'd2);
    chk("t2_fill_full", 64'(fill), 64'd8);
    chk("t2_tready_full", 64'(s_if.tready), 64'd0);
    set_beat(64'hA008, 8'hFF, 1'b0, 8'd1, 8'd2);
    rd_en = 1'b1;
    @(negedge clk);
    chk("t2_tready_during_pop", 64'(s_if.tready), 64'd0);
    cyc();
    rd_en = 1'b0;
    chk("t2_tready_after_pop", 64'(s_if.tready), 64'd1);
    chk("t2_fill_after_pop", 64'(fill), 64'd7);
    cyc();
    s_if.tvalid = 1'b0;
    chk("t2_fill_9th", 64'(fill), 64'd8);
    chk("t2_tready_refull", 64'(s_if.tready), 64'd0);
    pop(8);
    send(64'hA009, 8'hFF, 1'b1, 8'd1, 8'd2);
    pop(1);
    chk("t2_fill_drained", 64'(fill), 64'd0);
    chk("t2_in_pkt", 64'(in_pkt), 64'd0);

    // streaming at fill=1
    send(64'hB000, 8'hFF, 1'b0, 8'd2, 8'd3);
    for (int i = 0; i < 20; i++) begin
      set_beat({$urandom, $urandom}, 8'($urandom_range(1, 255)), (i == 19), 8'd2, 8'd3);
      rd_en = 1'b1;
      cyc();
      chk("t3_fill_steady", 64'(fill), 64'd1);
    end
    s_if.tvalid = 1'b0;
    pop(1);
    chk("t3_fill_end", 64'(fill), 64'd0);

    // null beat discarded, empty-keep tlast beat kept
    send(64'hC0C0, 8'hFF, 1'b0, 8'd3, 8'd4);
    send(64'hC1C1, 8'h00, 1'b0, 8'd3, 8'd4);
    send(64'hC2C2, 8'h00, 1'b1, 8'd3, 8'd4);
    chk("t4_fill", 64'(fill), 64'd2);
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkts));
    chk("t4_pkt_cnt_abs", 64'(pkt_cnt), 64'd4);
    pop(2);
    chk("t4_in_pkt", 64'(in_pkt), 64'd0);

    // header violations and err_clr priority
    send(64'hD000, 8'hFF, 1'b0, 8'd5, 8'd6);
    chk("t5_err_clean", 64'(err_hdr), 64'd0);
    send(64'hD001, 8'hFF, 1'b0, 8'd6, 8'd6);
    chk("t5_err_set", 64'(err_hdr), 64'd1);
    cyc();
    chk("t5_err_sticky", 64'(err_hdr), 64'd1);
    err_clr = 1'b1;
    send(64'hD002, 8'hFF, 1'b0, 8'd7, 8'd6);
    err_clr = 1'b0;
    chk("t5_set_wins", 64'(err_hdr), 64'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t5_err_cleared", 64'(err_hdr), 64'd0);
    send(64'hD003, 8'hFF, 1'b1, 8'd5, 8'd6);
    chk("t5_err_after_good", 64'(err_hdr), 64'd0);
    pop(4);

    // reset mid-packet
    for (int i = 0; i < 4; i++) send(64'(i) + 64'hE000, 8'hFF, 1'b0, 8'd9, 8'd9);
    chk("t6_fill_pre", 64'(fill), 64'd4);
    chk("t6_in_pkt_pre", 64'(in_pkt), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_fill_rst", 64'(fill), 64'd0);
    chk("t6_in_pkt_rst", 64'(in_pkt), 64'd0);
    chk("t6_rd_valid_rst", 64'(rd_valid), 64'd0);
    chk("t6_tready_rst", 64'(s_if.tready), 64'd0);
    sb.delete();
    exp_pkts = 0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    send(64'hF00D, 8'h0F, 1'b1, 8'd4, 8'd4);
    chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("t6_in_pkt", 64'(in_pkt), 64'd0);
    chk("t6_err", 64'(err_hdr), 64'd0);
    chk("t6_fill", 64'(fill), 64'd1);
    pop(1);
    chk("end_fill", 64'(fill), 64'd0);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
